// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampling UART receiver (start, DATA_BITS LSB-first, even parity, stop).
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer before use.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 p_rx;
    logic                 rx_s;
    logic                 prev_s;
    logic                 samp;
    logic                 last_bit;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;
    // two-flop synchronizer, resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];
`else
    assign rx_s = rx;
`endif

    // sample point: mid-bit in START, end of a full bit period elsewhere
    assign samp     = tick && (cnt == ((state == START) ? CW'(OVERSAMPLE/2 - 1) : CW'(OVERSAMPLE - 1)));
    assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic; a held-low line never retriggers since a 1->0 edge is required
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (prev_s && !rx_s) ? START : IDLE;
            START:   state_nx = samp ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_nx = (samp && last_bit) ? PARITY : DATA;
            PARITY:  state_nx = samp ? STOP : PARITY;
            STOP:    state_nx = samp ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // datapath: oversample counter, shift register and registered result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_s     <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            p_rx       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            prev_s   <= rx_s;
            rx_valid <= 1'b0;
            if (state == IDLE)
                cnt <= '0;
            else if (tick)
                cnt <= samp ? '0 : cnt + CW'(1);
            if (state == START && samp)
                bit_cnt <= '0;
            if (state == DATA && samp) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == PARITY && samp)
                p_rx <= rx_s;
            if (state == STOP && samp) begin
                rx_data    <= shreg;
                parity_err <= (p_rx != ^shreg);
                frame_err  <= !rx_s;
                rx_valid   <= 1'b1;
            end
        end
    end
endmodule
